// File: rtl/sd_adc_pkg.sv
// Shared constants and helpers for the single-bit sigma-delta capture path.
package sd_adc_pkg;

    localparam int SAMPLE_W       = 8;
    localparam int EXCESS         = 128;
    localparam int DECIM_LOG2_MIN = 4;
    localparam int DECIM_LOG2_MAX = 12;

    // Integrator width that holds a full sinc^2 frame (2^(2d)) with one bit of headroom.
    function automatic int acc_width(input int d);
        return 2 * d + 1;
    endfunction

endpackage

// File: rtl/sinc2_decimator.sv
// Second-order CIC (sinc^2) decimator: bitstream in, scaled 8-bit result and frame tick out.
module sinc2_decimator
    import sd_adc_pkg::*;
#(
    parameter int DECIM_LOG2 = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sd_bit,
    output logic                tick,
    output logic [SAMPLE_W-1:0] r
);

    localparam int W     = acc_width(DECIM_LOG2);
    localparam int SHIFT = 2 * DECIM_LOG2 - SAMPLE_W;

    logic [W-1:0]            acc1;
    logic [W-1:0]            acc2;
    logic [W-1:0]            d1;
    logic [W-1:0]            d2;
    logic [W-1:0]            c1;
    logic [W-1:0]            c2;
    logic [DECIM_LOG2-1:0]   dcnt;

    // Full-scale input yields exactly 2^(2D), which scales to 256 and must clip to 255.
    function automatic logic [SAMPLE_W-1:0] scale_sat(input logic [W-1:0] v);
        logic [W-1:0] s;
        s = v >> SHIFT;
        if (s > W'(2 * EXCESS - 1))
            return '1;
        return s[SAMPLE_W-1:0];
    endfunction

    assign tick = &dcnt;
    assign c1   = acc2 - d1;
    assign c2   = c1 - d2;
    assign r    = scale_sat(c2);

    // Integrators wrap modulo 2^W by design; the comb differences undo the wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc1 <= '0;
            acc2 <= '0;
            d1   <= '0;
            d2   <= '0;
            dcnt <= '0;
        end else begin
            acc1 <= acc1 + W'(sd_bit);
            acc2 <= acc2 + acc1;
            dcnt <= dcnt + DECIM_LOG2'(1);
            if (tick) begin
                d1 <= acc2;
                d2 <= c1;
            end
        end
    end

endmodule

// File: rtl/sigma_delta_adc.sv
// Sigma-delta ADC front end: comparator synchroniser, RC feedback flop, sinc^2 decimation and sample handshake.
module sigma_delta_adc
    import sd_adc_pkg::*;
#(
    parameter int DECIM_LOG2 = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmp_in,
    output logic                fb_out,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun
);

    if (DECIM_LOG2 < DECIM_LOG2_MIN || DECIM_LOG2 > DECIM_LOG2_MAX) begin : g_bad_decim
        $error("sigma_delta_adc: DECIM_LOG2 outside the supported range 4..12");
    end

    localparam logic [1:0] WARM_DONE = 2'd2;

    logic                cmp_p0;
    logic                cmp_p1;
    logic                tick;
    logic [SAMPLE_W-1:0] r;
    logic [1:0]          warm;

    sinc2_decimator #(
        .DECIM_LOG2 (DECIM_LOG2)
    ) u_dec (
        .clk    (clk),
        .reset  (reset),
        .sd_bit (cmp_p1),
        .tick   (tick),
        .r      (r)
    );

    // Stage boundary: asynchronous comparator -> two-flop synchroniser -> feedback pin flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_p0 <= 1'b0;
            cmp_p1 <= 1'b0;
            fb_out <= 1'b0;
        end else begin
            cmp_p0 <= cmp_in;
            cmp_p1 <= cmp_p0;
            fb_out <= cmp_p1;
        end
    end

    // Stage boundary: decimator tick -> held sample; the first two frames only prime the comb.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm         <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (tick && warm != WARM_DONE)
                warm <= warm + 2'd1;
            if (tick && warm == WARM_DONE) begin
                sample       <= r;
                sample_valid <= 1'b1;
                if (sample_valid && !sample_ready)
                    overrun <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sigma_delta_adc.sv
// Directed bench for sigma_delta_adc: reset, constant and alternating inputs, handshake, overrun, mid-frame reset.
module tb_sigma_delta_adc;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmp_in;
    logic       sample_ready;
    logic       ready8;
    logic       fb_out;
    logic       sample_valid;
    logic       overrun;
    logic [7:0] sample;
    logic       fb8;
    logic       valid8;
    logic       ovr8;
    logic [7:0] sample8;

    int checks = 0;
    int errors = 0;
    int k = 0;
    logic c_d1 = 1'b0;
    logic c_d2 = 1'b0;
    logic c_d3 = 1'b0;

    always #5 clk = ~clk;

    sigma_delta_adc #(.DECIM_LOG2(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmp_in       (cmp_in),
        .fb_out       (fb_out),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    sigma_delta_adc #(.DECIM_LOG2(8)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .cmp_in       (cmp_in),
        .fb_out       (fb8),
        .sample       (sample8),
        .sample_valid (valid8),
        .sample_ready (ready8),
        .overrun      (ovr8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, k, got, exp);
        end
    endtask

    // One clock edge; c_dN hold the cmp_in value driven N edges ago.
    task automatic step();
        @(posedge clk);
        #1;
        k++;
        c_d3 = c_d2;
        c_d2 = c_d1;
        c_d1 = cmp_in;
    endtask

    task automatic release_reset();
        reset = 1'b0;
        k     = 0;
        c_d1  = 1'b0;
        c_d2  = 1'b0;
        c_d3  = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        cmp_in       = 1'b0;
        sample_ready = 1'b0;
        ready8       = 1'b1;

        // Reset values, then cmp_in = 0 with a consumer that is always ready.
        repeat (5) step();
        chk("rst_fb",      32'(fb_out),       32'(0));
        chk("rst_sample",  32'(sample),       32'(0));
        chk("rst_valid",   32'(sample_valid), 32'(0));
        chk("rst_overrun", 32'(overrun),      32'(0));
        release_reset();
        sample_ready = 1'b1;
        for (int i = 0; i < 47; i++) begin
            step();
            chk("zero_prevalid", 32'(sample_valid), 32'(0));
        end
        for (int i = 0; i < 40; i++) begin
            step();
            chk("zero_valid",   32'(sample_valid), 32'(k % 16 == 0));
            chk("zero_sample",  32'(sample),       32'(8'h00));
            chk("zero_overrun", 32'(overrun),      32'(0));
        end

        // Alternating bitstream on both decimation settings; consumers always ready.
        reset  = 1'b1;
        cmp_in = 1'b0;
        repeat (5) step();
        release_reset();
        for (int i = 0; i < 800; i++) begin
            step();
            chk("alt_fb",      32'(fb_out),       32'(c_d3));
            chk("alt_valid",   32'(sample_valid), 32'(k >= 48 && k % 16 == 0));
            chk("alt_sample",  32'(sample),       (k >= 48) ? 32'h80 : 32'h00);
            chk("alt_overrun", 32'(overrun),      32'(0));
            chk("alt8_valid",  32'(valid8),       32'(k >= 768 && k % 256 == 0));
            chk("alt8_sample", 32'(sample8),      (k >= 768) ? 32'h80 : 32'h00);
            cmp_in = ~cmp_in;
        end

        // Full-scale input; consumer ready only during tick cycles (dcnt = 15).
        reset        = 1'b1;
        cmp_in       = 1'b1;
        sample_ready = 1'b0;
        repeat (5) step();
        release_reset();
        for (int i = 0; i < 112; i++) begin
            step();
            chk("one_fb",      32'(fb_out),       32'(c_d3));
            chk("one_valid",   32'(sample_valid), 32'(k >= 48));
            chk("one_sample",  32'(sample),       (k >= 48) ? 32'hFF : 32'h00);
            chk("one_overrun", 32'(overrun),      32'(0));
            sample_ready = (k % 16 == 15);
        end

        // No consumer across two ticks while the input drops to 0: overrun is sticky, newer sample wins.
        sample_ready = 1'b0;
        cmp_in       = 1'b0;
        for (int i = 0; i < 57; i++) begin
            step();
            chk("ovr_flag",  32'(overrun),      32'(k >= 128));
            chk("ovr_valid", 32'(sample_valid), 32'(1));
            chk("ovr_fb",    32'(fb_out),       32'(c_d3));
            if (k >= 160)
                chk("ovr_sample", 32'(sample), 32'(8'h00));
            if (k == 165)
                cmp_in = 1'b1;
        end

        // Reset at dcnt = 9 with a pending sample: everything clears on the next edge.
        reset = 1'b1;
        step();
        chk("mid_fb",      32'(fb_out),       32'(0));
        chk("mid_sample",  32'(sample),       32'(0));
        chk("mid_valid",   32'(sample_valid), 32'(0));
        chk("mid_overrun", 32'(overrun),      32'(0));
        release_reset();
        sample_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            step();
            chk("re_valid",   32'(sample_valid), 32'(k >= 48 && k % 16 == 0));
            chk("re_sample",  32'(sample),       (k >= 48) ? 32'hFF : 32'h00);
            chk("re_overrun", 32'(overrun),      32'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sigma_delta_adc.md
# sigma_delta_adc

Single-bit sigma-delta ADC front end, the capture-side counterpart of the board's delta-sigma DAC. It samples an external comparator through a 2-FF synchroniser and drives the RC feedback pin with the registered bit. A sinc² (CIC order 2) filter decimates the bitstream into 8-bit excess-128 samples, in the same format the DAC consumes. Samples are delivered on a valid/ready handshake to audio, tape-in or loopback logic on the 14 MHz domain.

## Interface
- `DECIM_LOG2`, default 8: decimation factor is 2^DECIM_LOG2; legal range 4..12. At 14 MHz, 8 gives about 54.7 kHz.
- `clk` in 1: system clock, 14 MHz.
- `reset` in 1: synchronous, active-high reset.
- `cmp_in` in 1: asynchronous comparator output (analog + vs integrated feedback).
- `fb_out` out 1: feedback bit to the RC network; reset value 0.
- `sample` out 8: decimated sample, excess-128; reset value 8'h00.
- `sample_valid` out 1: sample held and available; reset value 0.
- `sample_ready` in 1: consumer accepts `sample` on a cycle where `sample_valid` is also high.
- `overrun` out 1: sticky flag, set when an unconsumed sample is overwritten; reset value 0.

## Operation
- **Synchroniser:** `cmp_in` passes through two flops to give `bit`. `fb_out` is `bit` registered, so it is an IOB-friendly flop with no combinational path to the pin.
- **Integrators:** width W = 2·DECIM_LOG2 + 1. Every cycle, acc1 += bit and acc2 += acc1. Arithmetic is unsigned modulo 2^W; wrap-around is intentional and must not be saturated.
- **Decimation counter:** `dcnt` is DECIM_LOG2 bits and free-runs from 0 to 2^D−1. A tick fires on the cycle where `dcnt` is at its maximum.
- **Comb on each tick:**
  - c1 = acc2 − d1, then d1 ← acc2.
  - c2 = c1 − d2, then d2 ← c1.
  - Both subtractions are modulo 2^W.
- **Scaling:** c2 lies in 0..2^(2D). The result r = c2 >> (2D−8). If r = 256 (full-scale all ones), it saturates to 255.
- **Settling:** the first 2 ticks after reset update the comb state but produce no output. A counter `warm` runs 0→2.
- **Output register, on a post-warm-up tick:**
  - `sample` ← r and `sample_valid` ← 1.
  - If `sample_valid` was already 1 and `sample_ready` is 0 that cycle, the old sample is lost and `overrun` ← 1.
  - If `sample_ready` is 1 in the same cycle as a tick, the old sample transfers, the new one loads, `sample_valid` stays 1, and no overrun is raised.
- **Handshake without a tick:** `sample_valid` && `sample_ready` → `sample_valid` ← 0. `sample` holds its last value.
- **`sample_ready` while `sample_valid` is 0** is ignored.
- **`overrun`** clears only on `reset`.
- **Reset, including mid-operation:** all state clears on the next edge, including the synchroniser, `fb_out`, acc1/acc2, d1/d2, `dcnt`, `warm`, and the outputs. Any pending sample is discarded.

## Timing
- `cmp_in` to `bit`: 2 cycles. `bit` to `fb_out`: 1 cycle.
- Tick cycle to `sample_valid` high / new `sample`: 1 cycle, i.e. registered at the edge ending the tick cycle.
- The first `sample_valid` appears 1 cycle after the 3rd tick, which is cycle 3·2^D after reset release.
- After warm-up, `sample_valid` rises exactly every 2^D cycles if consumed.
- The consumer has 2^D − 1 cycles to accept a sample before overrun is possible.
- The filter has no backpressure. The data path never stalls.

## Structure
- **Package `sd_adc_pkg`:**
  - `SAMPLE_W` = 8.
  - `EXCESS` = 128.
  - Function `acc_width(d)` = 2d+1.
  - `DECIM_LOG2` legality limits (min 4, max 12), used by the top-level elaboration check.
- **Sub-module `sinc2_decimator`:**
  - Inputs: `bit`, `clk`, `reset`.
  - Outputs: `tick`, `r[7:0]`.
  - Contains the integrators, comb, `dcnt` and the scaling/saturation.
- **Top level:** holds the synchroniser, `fb_out`, warm-up counter, handshake register and overrun logic.

## Test plan
All scenarios use DECIM_LOG2 = 4 (W = 9, shift 0) unless stated.
- **Reset:** hold `reset` for 5 cycles → `fb_out`, `sample`, `sample_valid` and `overrun` are all 0. No `sample_valid` before cycle 48. First valid at cycle 48.
- **Constant levels:** `cmp_in` = 0 → every sample is 8'h00. `cmp_in` = 1 → every settled sample is 8'hFF (saturated from 256). `fb_out` tracks `cmp_in` delayed by 3 cycles.
- **Alternating input:** `cmp_in` toggles each cycle → settled samples are 8'h80 ± 0. With DECIM_LOG2 = 8, the same stimulus gives 8'h80 (shift 8).
- **Handshake:**
  - `sample_ready` = 1 permanently → `sample_valid` is a 1-cycle pulse every 16 cycles and `overrun` stays 0.
  - `sample_ready` high only in the tick cycle → no overrun and `sample_valid` stays high.
- **Overrun:** `sample_ready` = 0 across two post-warm-up ticks → `overrun` is 1 one cycle after the 2nd tick and `sample` shows the newer value. `overrun` remains 1 until `reset`.
- **Reset mid-frame:** assert `reset` at `dcnt` = 9 with `sample_valid` high → everything clears next edge. Warm-up restarts and the first new valid appears 48 cycles after release.
